// File: rtl/fsm_pkg.sv
// fsm_pkg: shared state encoding for the fsm two-phase pulse sequencer.
package fsm_pkg;
  localparam int ST_W = 2;
  typedef enum logic [ST_W-1:0] {
    S_IDLE = 2'b00,
    S_PH_P = 2'b01,
    S_PH_Q = 2'b10,
    S_BAD  = 2'b11
  } state_t;
endpackage

// File: rtl/fsm_phase_cnt.sv
// fsm_phase_cnt: loadable down-counter with zero flag, shared by both phases.
module fsm_phase_cnt
  import fsm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/fsm.sv
// fsm: jump-triggered sequencer emitting a P_CYCLES dout_p window then a Q_CYCLES dout_q window.
// Optional FSM_RETRIGGER_EN: jump sampled in PH_Q restarts phase P.
module fsm
  import fsm_pkg::*;
#(
  parameter int P_CYCLES = 4,
  parameter int Q_CYCLES = 4,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic jump,
  output logic dout_p,
  output logic dout_q
);
  state_t           r_state, w_next;
  logic             r_dout_p, r_dout_q;
  logic             w_load, w_en, w_zero, w_retrig;
  logic [CNT_W-1:0] w_load_val;
`ifdef FSM_RETRIGGER_EN
  assign w_retrig = jump;
`else
  assign w_retrig = 1'b0;
`endif
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_en       = 1'b0;
    w_load_val = CNT_W'(P_CYCLES - 1);
    case (r_state)
      S_IDLE: if (jump) begin
        w_next = S_PH_P;
        w_load = 1'b1;
      end
      S_PH_P: if (w_zero) begin
        w_next     = S_PH_Q;
        w_load     = 1'b1;
        w_load_val = CNT_W'(Q_CYCLES - 1);
      end else w_en = 1'b1;
      S_PH_Q: if (w_retrig) begin
        w_next = S_PH_P;
        w_load = 1'b1;
      end else if (w_zero) w_next = S_IDLE;
      else w_en = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end
  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_dout_p <= 1'b0;
      r_dout_q <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_dout_p <= (w_next == S_PH_P);
      r_dout_q <= (w_next == S_PH_Q);
    end
  fsm_phase_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_en       (w_en),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );
  assign dout_p = r_dout_p;
  assign dout_q = r_dout_q;
endmodule

// File: tb/tb_fsm.sv
// tb_fsm: scoreboard bench for fsm with a 4/4 instance and a 1/1 instance driven by one jump.
module tb_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic jump = 1'b0;
  logic p4, q4, p1, q1;
  int n_vec = 0;
  int n_err = 0;
  logic [3:0] sb[$];
  int m[2] = '{0, 0};
  int left[2] = '{0, 0};
  int plen[2] = '{4, 1};
  int qlen[2] = '{4, 1};

  always #5 clk = ~clk;

  fsm #(.P_CYCLES(4), .Q_CYCLES(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .jump(jump), .dout_p(p4), .dout_q(q4));
  fsm #(.P_CYCLES(1), .Q_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .jump(jump), .dout_p(p1), .dout_q(q1));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: remaining-cycle count per phase, advanced once per clock edge.
  task automatic model_edge(input logic j);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) m[i] = 0;
      else if (m[i] == 0) begin
        if (j) begin m[i] = 1; left[i] = plen[i]; end
      end else if (m[i] == 1) begin
        left[i]--;
        if (left[i] == 0) begin m[i] = 2; left[i] = qlen[i]; end
      end else begin
`ifdef FSM_RETRIGGER_EN
        if (j) begin m[i] = 1; left[i] = plen[i]; end
        else begin
          left[i]--;
          if (left[i] == 0) m[i] = 0;
        end
`else
        left[i]--;
        if (left[i] == 0) m[i] = 0;
`endif
      end
    end
  endtask

  task automatic step(input logic j);
    logic [3:0] e;
    @(negedge clk);
    jump = j;
    model_edge(j);
    sb.push_back({m[0] == 1, m[0] == 2, m[1] == 1, m[1] == 2});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("p4", 8'(p4), 8'(e[3]));
    chk("q4", 8'(q4), 8'(e[2]));
    chk("p1", 8'(p1), 8'(e[1]));
    chk("q1", 8'(q1), 8'(e[0]));
    chk("mutex", 8'({p4 & q4, p1 & q1}), 8'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    idle(10);
    rst_n = 1'b1;
    idle(2);
    step(1'b1);
    idle(11);
    step(1'b1);
    step(1'b1);
    idle(10);
    for (int i = 0; i < 24; i++) step(1'b1);
    idle(12);
    step(1'b1);
    idle(5);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_p4", 8'(p4), 8'd0);
    chk("arst_q4", 8'(q4), 8'd0);
    chk("arst_p1", 8'(p1), 8'd0);
    chk("arst_q1", 8'(q1), 8'd0);
    m = '{0, 0};
    #1 rst_n = 1'b1;
    idle(2);
    step(1'b1);
    idle(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
